// File: rtl/ecc_scrub_ctrl_if.sv
// Memory / user / ECC-checker bus bundle for ecc_scrub_ctrl.
// master: the scrub controller (arbitrates the user requests onto the memory
//         ports and drives the external checker inputs).
// slave : the surrounding environment (user port, memory macro, checker).
// Signals:
//   usr_rd_en/usr_rd_addr, usr_wr_en/usr_wr_addr/usr_wr_data : user requests
//   mem_rd_en/mem_rd_addr, mem_rd_data (1-cycle latency)      : memory read port
//   mem_wr_en/mem_wr_addr/mem_wr_data                         : memory write port
//   ecc_data_in/ecc_parity_in/ecc_bypass                      : to checker
//   ecc_data_out/ecc_parity_out/ecc_sbit_err/ecc_dbit_err     : from checker
interface ecc_scrub_ctrl_if #(
  parameter int unsigned DATA_WIDTH   = 53,
  parameter int unsigned PARITY_WIDTH = 7,
  parameter int unsigned ADDR_WIDTH   = 6
);
  localparam int unsigned WORD_WIDTH = DATA_WIDTH + PARITY_WIDTH;

  logic                    usr_rd_en;
  logic [ADDR_WIDTH-1:0]   usr_rd_addr;
  logic                    usr_wr_en;
  logic [ADDR_WIDTH-1:0]   usr_wr_addr;
  logic [WORD_WIDTH-1:0]   usr_wr_data;

  logic                    mem_rd_en;
  logic [ADDR_WIDTH-1:0]   mem_rd_addr;
  logic [WORD_WIDTH-1:0]   mem_rd_data;
  logic                    mem_wr_en;
  logic [ADDR_WIDTH-1:0]   mem_wr_addr;
  logic [WORD_WIDTH-1:0]   mem_wr_data;

  logic [DATA_WIDTH-1:0]   ecc_data_in;
  logic [PARITY_WIDTH-1:0] ecc_parity_in;
  logic                    ecc_bypass;
  logic [DATA_WIDTH-1:0]   ecc_data_out;
  logic [PARITY_WIDTH-1:0] ecc_parity_out;
  logic                    ecc_sbit_err;
  logic                    ecc_dbit_err;

  modport master (
    input  usr_rd_en, usr_rd_addr, usr_wr_en, usr_wr_addr, usr_wr_data,
    output mem_rd_en, mem_rd_addr, mem_wr_en, mem_wr_addr, mem_wr_data,
    input  mem_rd_data,
    output ecc_data_in, ecc_parity_in, ecc_bypass,
    input  ecc_data_out, ecc_parity_out, ecc_sbit_err, ecc_dbit_err
  );

  modport slave (
    output usr_rd_en, usr_rd_addr, usr_wr_en, usr_wr_addr, usr_wr_data,
    input  mem_rd_en, mem_rd_addr, mem_wr_en, mem_wr_addr, mem_wr_data,
    output mem_rd_data,
    input  ecc_data_in, ecc_parity_in, ecc_bypass,
    output ecc_data_out, ecc_parity_out, ecc_sbit_err, ecc_dbit_err
  );
endinterface

// File: rtl/ecc_scrub_ctrl.sv
// Background ECC scrubber and read/write port arbiter for a SECDED array
// stored as {parity, data}. The user path always wins both ports with zero
// added latency; the scrub engine walks 0..DEPTH-1, corrects single-bit
// errors by writeback and logs error statistics.
// Ports:
//   clk, rst        : clock, asynchronous active-high reset
//   scrub_en        : scrub enable
//   interval        : idle cycles between scrub words
//   cnt_clr         : synchronous clear of counters, dbit_flag, dbit_addr
//   bus             : user / memory / checker bundle (master side)
//   scrub_busy      : FSM not in IDLE
//   pass_done       : one-cycle pulse after the last address completes
//   sbit_cnt/dbit_cnt : saturating error counters
//   dbit_addr/dbit_flag : last double-bit error address, sticky flag
module ecc_scrub_ctrl #(
  parameter int unsigned DATA_WIDTH   = 53,
  parameter int unsigned PARITY_WIDTH = 7,
  parameter int unsigned ADDR_WIDTH   = 6,
  parameter int unsigned DEPTH        = 64,
  parameter int unsigned CNT_WIDTH    = 16,
  parameter int unsigned IVL_WIDTH    = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  scrub_en,
  input  logic [IVL_WIDTH-1:0]  interval,
  input  logic                  cnt_clr,
  ecc_scrub_ctrl_if.master      bus,
  output logic                  scrub_busy,
  output logic                  pass_done,
  output logic [CNT_WIDTH-1:0]  sbit_cnt,
  output logic [CNT_WIDTH-1:0]  dbit_cnt,
  output logic [ADDR_WIDTH-1:0] dbit_addr,
  output logic                  dbit_flag
);
  localparam int unsigned WORD_WIDTH = DATA_WIDTH + PARITY_WIDTH;

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT, S_RD, S_CHK, S_WB, S_NEXT
  } state_t;

  state_t                  state, state_nxt;
  logic [ADDR_WIDTH-1:0]   addr;
  logic [IVL_WIDTH-1:0]    ivl_cnt;
  logic                    coll;
  logic                    stop;
  logic [WORD_WIDTH-1:0]   wb_word;
  logic                    scrub_rd, scrub_wr;
  logic                    wr_hit, last_addr;
  logic [DATA_WIDTH-1:0]   raw_data;
  logic [PARITY_WIDTH-1:0] raw_par, wb_par;
  logic [CNT_WIDTH-1:0]    sbit_nxt, dbit_nxt;
  logic                    chk_dbit, chk_sbit;

  // Checker is fed straight from the memory read data
  assign raw_data          = bus.mem_rd_data[DATA_WIDTH-1:0];
  assign raw_par           = bus.mem_rd_data[WORD_WIDTH-1:DATA_WIDTH];
  assign bus.ecc_data_in   = raw_data;
  assign bus.ecc_parity_in = raw_par;
  assign bus.ecc_bypass    = 1'b0;

  assign wr_hit    = bus.usr_wr_en && (bus.usr_wr_addr == addr);
  assign last_addr = (addr == ADDR_WIDTH'(DEPTH - 1));
  assign chk_dbit  = (state == S_CHK) && bus.ecc_dbit_err;
  assign chk_sbit  = (state == S_CHK) && !bus.ecc_dbit_err && bus.ecc_sbit_err;

  // Unchanged data means the flipped bit was a parity bit: take recomputed parity
  assign wb_par = (bus.ecc_data_out == raw_data) ? bus.ecc_parity_out : raw_par;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (scrub_en) state_nxt = S_WAIT;
      S_WAIT: begin
        if (!scrub_en)             state_nxt = S_IDLE;
        else if (ivl_cnt == '0)    state_nxt = S_RD;
      end
      S_RD:   if (!bus.usr_rd_en) state_nxt = S_CHK;
      S_CHK:  state_nxt = chk_sbit ? S_WB : S_NEXT;
      S_WB:   if (!bus.usr_wr_en) state_nxt = S_NEXT;
      S_NEXT: state_nxt = (scrub_en && !stop) ? S_WAIT : S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Scrub-side port requests
  always_comb begin
    scrub_rd = 1'b0;
    scrub_wr = 1'b0;
    if (state == S_RD && !bus.usr_rd_en)         scrub_rd = 1'b1;
    if (state == S_WB && !bus.usr_wr_en && !coll) scrub_wr = 1'b1;
  end

  // Port arbitration: user requests take priority on both ports
  always_comb begin
    bus.mem_rd_en   = bus.usr_rd_en | scrub_rd;
    bus.mem_rd_addr = bus.usr_rd_en ? bus.usr_rd_addr : addr;
    bus.mem_wr_en   = bus.usr_wr_en | scrub_wr;
    bus.mem_wr_addr = bus.usr_wr_en ? bus.usr_wr_addr : addr;
    bus.mem_wr_data = bus.usr_wr_en ? bus.usr_wr_data : wb_word;
  end

  // Saturating counters; clear wins over a same-cycle increment
  always_comb begin
    sbit_nxt = sbit_cnt;
    dbit_nxt = dbit_cnt;
    if (chk_sbit && sbit_cnt != '1) sbit_nxt = sbit_cnt + CNT_WIDTH'(1);
    if (chk_dbit && dbit_cnt != '1) dbit_nxt = dbit_cnt + CNT_WIDTH'(1);
    if (cnt_clr) begin
      sbit_nxt = '0;
      dbit_nxt = '0;
    end
  end

  // Scrub datapath and status registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr       <= '0;
      ivl_cnt    <= '0;
      coll       <= 1'b0;
      stop       <= 1'b0;
      wb_word    <= '0;
      sbit_cnt   <= '0;
      dbit_cnt   <= '0;
      dbit_addr  <= '0;
      dbit_flag  <= 1'b0;
      pass_done  <= 1'b0;
      scrub_busy <= 1'b0;
    end else begin
      sbit_cnt   <= sbit_nxt;
      dbit_cnt   <= dbit_nxt;
      pass_done  <= 1'b0;
      scrub_busy <= (state_nxt != S_IDLE);
      if (cnt_clr) begin
        dbit_flag <= 1'b0;
        dbit_addr <= '0;
      end else if (chk_dbit) begin
        dbit_flag <= 1'b1;
        dbit_addr <= addr;
      end
      case (state)
        S_IDLE: begin
          ivl_cnt <= interval;
          stop    <= 1'b0;
        end
        S_WAIT: if (ivl_cnt != '0) ivl_cnt <= ivl_cnt - IVL_WIDTH'(1);
        S_RD: begin
          // Re-evaluated each stall cycle so it reflects the actual issue cycle
          coll <= wr_hit;
          if (!scrub_en) stop <= 1'b1;
        end
        S_CHK: begin
          coll    <= coll | wr_hit;
          wb_word <= {wb_par, bus.ecc_data_out};
          if (!scrub_en) stop <= 1'b1;
        end
        S_WB: begin
          coll <= coll | wr_hit;
          if (!scrub_en) stop <= 1'b1;
        end
        S_NEXT: begin
          addr      <= last_addr ? '0 : addr + ADDR_WIDTH'(1);
          pass_done <= last_addr;
          ivl_cnt   <= interval;
          stop      <= 1'b0;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_ecc_scrub_ctrl.sv
// Self-checking bench for ecc_scrub_ctrl: behavioural memory, SECDED checker
// model and a scoreboard of expected scrub writebacks.
module tb_ecc_scrub_ctrl;
  localparam int unsigned DW    = 53;
  localparam int unsigned PW    = 7;
  localparam int unsigned AW    = 6;
  localparam int unsigned DEPTH = 64;
  localparam int unsigned CW    = 16;
  localparam int unsigned IW    = 16;
  localparam int unsigned WW    = DW + PW;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [WW-1:0] data;
  } wb_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          scrub_en;
  logic [IW-1:0] interval;
  logic          cnt_clr;
  logic          scrub_busy, pass_done, dbit_flag;
  logic [CW-1:0] sbit_cnt, dbit_cnt;
  logic [AW-1:0] dbit_addr;

  ecc_scrub_ctrl_if #(.DATA_WIDTH(DW), .PARITY_WIDTH(PW), .ADDR_WIDTH(AW)) bus ();

  ecc_scrub_ctrl #(
    .DATA_WIDTH(DW), .PARITY_WIDTH(PW), .ADDR_WIDTH(AW),
    .DEPTH(DEPTH), .CNT_WIDTH(CW), .IVL_WIDTH(IW)
  ) dut (
    .clk(clk), .rst(rst), .scrub_en(scrub_en), .interval(interval),
    .cnt_clr(cnt_clr), .bus(bus), .scrub_busy(scrub_busy),
    .pass_done(pass_done), .sbit_cnt(sbit_cnt), .dbit_cnt(dbit_cnt),
    .dbit_addr(dbit_addr), .dbit_flag(dbit_flag)
  );

  always #5 clk = ~clk;

  int  n_tests = 0;
  int  n_fail  = 0;
  int  pass_cnt = 0;
  int  scrub_wr_cnt = 0;
  wb_t exp_q[$];
  logic [WW-1:0] mem  [DEPTH];
  logic [WW-1:0] gold [DEPTH];

  // Hamming position of data bit j (skips power-of-two check positions)
  function automatic logic [5:0] dpos(input int j);
    logic [5:0] r = '0;
    int k = 0;
    for (int p = 3; p < 64; p++) begin
      if ((p & (p - 1)) != 0) begin
        if (k == j) r = 6'(p);
        k++;
      end
    end
    return r;
  endfunction

  // {overall parity, 6 Hamming check bits}
  function automatic logic [PW-1:0] enc(input logic [DW-1:0] d);
    logic [5:0] c = '0;
    for (int j = 0; j < int'(DW); j++) if (d[j]) c = c ^ dpos(j);
    return {(^d) ^ (^c), c};
  endfunction

  // Memory macro: one-cycle read latency
  always @(posedge clk) begin
    if (bus.mem_wr_en) mem[bus.mem_wr_addr] <= bus.mem_wr_data;
    if (bus.mem_rd_en) bus.mem_rd_data <= mem[bus.mem_rd_addr];
  end

  // External combinational SECDED checker
  logic [DW-1:0] ck_dc;
  logic [PW-1:0] ck_pn;
  logic [5:0]    ck_syn;
  logic          ck_ov;
  always_comb begin
    ck_pn  = enc(bus.ecc_data_in);
    ck_syn = ck_pn[5:0] ^ bus.ecc_parity_in[5:0];
    ck_ov  = (^bus.ecc_data_in) ^ (^bus.ecc_parity_in);
    ck_dc  = bus.ecc_data_in;
    if (ck_ov) begin
      for (int j = 0; j < int'(DW); j++)
        if (dpos(j) == ck_syn) ck_dc[j] = ~bus.ecc_data_in[j];
    end
    bus.ecc_data_out   = ck_dc;
    bus.ecc_parity_out = ck_pn;
    bus.ecc_sbit_err   = ck_ov;
    bus.ecc_dbit_err   = !ck_ov && (ck_syn != 6'd0);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scrub writeback monitor: pops the scoreboard
  always @(negedge clk) begin
    if (!rst && bus.mem_wr_en && !bus.usr_wr_en) begin
      scrub_wr_cnt++;
      if (exp_q.size() == 0) begin
        chk("unexpected_scrub_wr_addr", 64'(bus.mem_wr_addr), 64'hFFFF);
      end else begin
        wb_t e;
        e = exp_q.pop_front();
        chk("wb_addr", 64'(bus.mem_wr_addr), 64'(e.addr));
        chk("wb_data", 64'(bus.mem_wr_data), 64'(e.data));
      end
    end
    if (pass_done) pass_cnt++;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic usr_write(input int a, input logic [WW-1:0] w);
    bus.usr_wr_en   = 1'b1;
    bus.usr_wr_addr = AW'(a);
    bus.usr_wr_data = w;
    step();
    bus.usr_wr_en   = 1'b0;
  endtask

  task automatic push_wb(input int a);
    wb_t e;
    e.addr = AW'(a);
    e.data = gold[a];
    exp_q.push_back(e);
  endtask

  // Enable scrub, wait for pass_done, then stop and wait for IDLE
  task automatic run_pass(input string tag);
    logic seen = 1'b0;
    logic idle = 1'b0;
    scrub_en = 1'b1;
    for (int c = 0; c < 2000 && !seen; c++) begin
      step();
      if (pass_done) seen = 1'b1;
    end
    chk({tag, "_pass_done_seen"}, 64'(seen), 64'd1);
    scrub_en = 1'b0;
    for (int c = 0; c < 20 && !idle; c++) begin
      step();
      if (!scrub_busy) idle = 1'b1;
    end
    chk({tag, "_idle"}, 64'(idle), 64'd1);
  endtask

  initial begin
    logic [DW-1:0] d;
    logic [WW-1:0] uword, bad3;
    logic found;

    rst = 1'b1; scrub_en = 1'b0; interval = '0; cnt_clr = 1'b0;
    bus.usr_rd_en = 1'b0; bus.usr_rd_addr = '0;
    bus.usr_wr_en = 1'b0; bus.usr_wr_addr = '0; bus.usr_wr_data = '0;
    repeat (3) step();
    chk("rst_scrub_busy", 64'(scrub_busy), 64'd0);
    chk("rst_pass_done",  64'(pass_done),  64'd0);
    chk("rst_sbit_cnt",   64'(sbit_cnt),   64'd0);
    chk("rst_dbit_cnt",   64'(dbit_cnt),   64'd0);
    chk("rst_dbit_addr",  64'(dbit_addr),  64'd0);
    chk("rst_dbit_flag",  64'(dbit_flag),  64'd0);
    chk("rst_mem_rd_en",  64'(bus.mem_rd_en), 64'd0);
    chk("rst_mem_wr_en",  64'(bus.mem_wr_en), 64'd0);
    rst = 1'b0;
    step();

    // Fill memory with clean codewords through the user port
    for (int i = 0; i < int'(DEPTH); i++) begin
      d = DW'({$urandom(), $urandom()});
      gold[i] = {enc(d), d};
      usr_write(i, gold[i]);
    end

    // Clean pass, interval 0
    run_pass("clean");
    chk("clean_pass_cnt", 64'(pass_cnt), 64'd1);
    chk("clean_sbit_cnt", 64'(sbit_cnt), 64'd0);
    chk("clean_dbit_cnt", 64'(dbit_cnt), 64'd0);
    chk("clean_no_wr",    64'(scrub_wr_cnt), 64'd0);

    // Data-bit error @5, parity-bit error @9, double error @12
    usr_write(5,  gold[5]  ^ WW'(1));
    usr_write(9,  gold[9]  ^ (WW'(1) << (DW + 3)));
    usr_write(12, gold[12] ^ WW'(3));
    push_wb(5);
    push_wb(9);
    run_pass("err");
    chk("err_pass_cnt",  64'(pass_cnt), 64'd2);
    chk("err_sbit_cnt",  64'(sbit_cnt), 64'd2);
    chk("err_dbit_cnt",  64'(dbit_cnt), 64'd1);
    chk("err_dbit_addr", 64'(dbit_addr), 64'd12);
    chk("err_dbit_flag", 64'(dbit_flag), 64'd1);
    chk("err_q_empty",   64'(exp_q.size()), 64'd0);
    chk("err_wr_cnt",    64'(scrub_wr_cnt), 64'd2);
    chk("err_mem5",      64'(mem[5]),  64'(gold[5]));
    chk("err_mem9",      64'(mem[9]),  64'(gold[9]));
    chk("err_mem12",     64'(mem[12]), 64'(gold[12] ^ WW'(3)));
    cnt_clr = 1'b1;
    step();
    cnt_clr = 1'b0;
    chk("clr_sbit_cnt",  64'(sbit_cnt),  64'd0);
    chk("clr_dbit_cnt",  64'(dbit_cnt),  64'd0);
    chk("clr_dbit_addr", 64'(dbit_addr), 64'd0);
    chk("clr_dbit_flag", 64'(dbit_flag), 64'd0);
    usr_write(12, gold[12]);

    // User reads hold the scrub in RD; then a user write collides with CHK @1
    usr_write(1, gold[1] ^ (WW'(1) << 20));
    scrub_en = 1'b1;
    bus.usr_rd_en = 1'b1;
    for (int i = 0; i < 12; i++) begin
      bus.usr_rd_addr = AW'(i + 20);
      #1;
      chk("usr_rd_addr", 64'(bus.mem_rd_addr), 64'(i + 20));
      step();
      chk("usr_rd_data", 64'(bus.mem_rd_data), 64'(gold[i + 20]));
    end
    chk("stall_busy", 64'(scrub_busy), 64'd1);
    bus.usr_rd_en = 1'b0;
    #1;
    chk("scrub_rd_en",   64'(bus.mem_rd_en),   64'd1);
    chk("scrub_rd_addr", 64'(bus.mem_rd_addr), 64'd0);
    found = 1'b0;
    for (int c = 0; c < 50 && !found; c++) begin
      step();
      if (bus.mem_rd_en && bus.mem_rd_addr == AW'(1)) found = 1'b1;
    end
    chk("coll_rd1_seen", 64'(found), 64'd1);
    step();
    d = DW'({$urandom(), $urandom()});
    uword = {enc(d), d};
    usr_write(1, uword);
    gold[1] = uword;
    run_pass("coll");
    chk("coll_pass_cnt", 64'(pass_cnt), 64'd3);
    chk("coll_mem1",     64'(mem[1]),   64'(uword));
    chk("coll_sbit_cnt", 64'(sbit_cnt), 64'd1);
    chk("coll_wr_cnt",   64'(scrub_wr_cnt), 64'd2);

    // Saturation of sbit_cnt
    force dut.sbit_cnt = 16'hFFFF;
    step();
    step();
    release dut.sbit_cnt;
    #1;
    chk("sat_forced", 64'(sbit_cnt), 64'hFFFF);
    usr_write(2, gold[2] ^ (WW'(1) << 7));
    push_wb(2);
    run_pass("sat");
    chk("sat_sbit_cnt", 64'(sbit_cnt), 64'hFFFF);
    chk("sat_q_empty",  64'(exp_q.size()), 64'd0);
    chk("sat_mem2",     64'(mem[2]), 64'(gold[2]));
    chk("sat_pass_cnt", 64'(pass_cnt), 64'd4);

    // Reset while the scrub writeback is being driven
    bad3 = gold[3] ^ (WW'(1) << 30);
    usr_write(3, bad3);
    scrub_en = 1'b1;
    found = 1'b0;
    for (int c = 0; c < 100 && !found; c++) begin
      step();
      if (bus.mem_wr_en) found = 1'b1;
    end
    chk("wb_seen",      64'(found), 64'd1);
    chk("wb_seen_addr", 64'(bus.mem_wr_addr), 64'd3);
    rst = 1'b1;
    #1;
    chk("rstwb_mem_wr_en", 64'(bus.mem_wr_en), 64'd0);
    chk("rstwb_mem_rd_en", 64'(bus.mem_rd_en), 64'd0);
    chk("rstwb_busy",      64'(scrub_busy), 64'd0);
    chk("rstwb_pass_done", 64'(pass_done),  64'd0);
    chk("rstwb_sbit_cnt",  64'(sbit_cnt),   64'd0);
    chk("rstwb_dbit_cnt",  64'(dbit_cnt),   64'd0);
    chk("rstwb_dbit_addr", 64'(dbit_addr),  64'd0);
    chk("rstwb_dbit_flag", 64'(dbit_flag),  64'd0);
    scrub_en = 1'b0;
    step();
    step();
    rst = 1'b0;
    step();
    chk("rstwb_mem3_untouched", 64'(mem[3]), 64'(bad3));
    chk("final_q_empty", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
